if_id_stall_ctrl: RTL

IF_ID_STALL_CTRL -- requirements
Module: if_id_stall_ctrl

---
 rtl/if_id_stall_ctrl_pkg.sv | 16 +
 rtl/if_id_stall_ctrl_sat.sv | 35 +++
 rtl/if_id_stall_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/if_id_stall_ctrl_pkg.sv
// Shared CPU definitions for the IF/ID pipeline register and its stall control.
// Holds the bubble instruction, the stall FSM encoding and the default hazard window.
package if_id_stall_ctrl_pkg;

    // Instruction word used as a pipeline bubble
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    // Longest legal consecutive stall: ID + EXE + MEM hazard window
    localparam int MAX_STALL_DEF = 3;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_e;

endpackage

// File: rtl/if_id_stall_ctrl_sat.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
// Ports: clk, rst_n, clr_i (clear to 0), inc_i (increment), cnt_o (count, holds at all-ones).
module sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID pipeline register with hazard stall control: bubble injection, PC write
// enable, consecutive-stall watchdog (sticky hazard_err) and total stall counter.
// Ports: clk, rst_n (sync, active-low); if_stop, id_branch, if_inst, if_pc in;
// pc_we, id_inst, id_pc, id_valid, stall_cnt, hazard_err, stall_total out.
module if_id_stall_ctrl
    import if_id_stall_ctrl_pkg::*;
#(
    parameter int          MAX_STALL = MAX_STALL_DEF,
    parameter logic [31:0] NOP_INST  = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_stop,
    input  logic        id_branch,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        pc_we,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic [1:0]  stall_cnt,
    output logic        hazard_err,
    output logic [15:0] stall_total
);

    stall_state_e state_q;
    stall_state_e state_d;

    logic [31:0] inst_q;
    logic [31:0] inst_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        valid_q;
    logic        valid_d;
    logic        err_q;
    logic        err_d;

    // Delay-slot ISA: a decoded branch never flushes IF/ID, and a stall
    // raised alongside a branch is still honoured, so id_branch has no effect.
    logic unused_branch;
    assign unused_branch = id_branch;

    // Zero-cycle freeze of the PC while the hazard judge holds the stall
    assign pc_we = ~if_stop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     state_d = if_stop ? STALL : RUN;
            STALL:   state_d = if_stop ? STALL : RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        inst_d  = if_inst;
        pc_d    = if_pc;
        valid_d = 1'b1;
        if (if_stop) begin
            // Bubble: the fetched word stays in IF until the stall clears
            inst_d  = NOP_INST;
            pc_d    = pc_q;
            valid_d = 1'b0;
        end
    end

    // Watchdog: one more stall while already at the window limit
    always_comb begin
        err_d = err_q;
        if (if_stop && (int'(stall_cnt) == MAX_STALL)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Consecutive stalls: counts while stalled, cleared on the release edge
    sat_counter #(
        .W(2)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (~if_stop),
        .inc_i (if_stop),
        .cnt_o (stall_cnt)
    );

    sat_counter #(
        .W(16)
    ) u_stall_total (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .inc_i (if_stop),
        .cnt_o (stall_total)
    );

    assign id_inst    = inst_q;
    assign id_pc      = pc_q;
    assign id_valid   = valid_q;
    assign hazard_err = err_q;

endmodule
